alu_issue: RTL and testbench
============================

# alu_issue

Decode-and-issue stage between instruction fetch and `alu`. Accepts one RV32I instruction per cycle with its PC and register-file read data, and decodes OP, OP-IMM, BRANCH, LUI and AUIPC into the ALU mode `m` and operands `a`/`b`. It also produces the destination register and write-back enable. Results are presented to the execute stage through a two-entry skid buffer with valid/ready handshakes on both sides, so throughput stays at one instruction per cycle under backpressure.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 5.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage can accept; registered.
- `in_instr`  in  32  raw instruction word.
- `in_pc`  in  32  instruction address.
- `in_rs1_data`  in  32  register-file value for instr[19:15].
- `in_rs2_data`  in  32  register-file value for instr[24:20].
- `out_valid`  out  1  issued entry valid.
- `out_ready`  in  1  execute stage accepts.
- `out_m`  out  4  ALU mode.
- `out_a`, `out_b`  out  32  ALU operands.
- `out_rd`  out  5  destination register.
- `out_wb`  out  1  write-back enable.
- `out_branch`  out  1  entry is a conditional branch; consumer uses `cmp`.
- `out_illegal`  out  1  opcode or funct field not supported.

## Operation
- Transfer in occurs when `in_valid & in_ready`. Transfer out occurs when `out_valid & out_ready`.
- Decode is combinational on input fields. The decoded entry is written into the buffer on transfer in.
- OP (0110011):
  - `m={f7[5],f3}`, `a=rs1`, `b=rs2`.
  - Legal only if f7 is 0000000, or f7 is 0100000 with f3 ∈ {000,101}.
- OP-IMM (0010011):
  - f3 001/101 (shifts): `b={27'b0,instr[24:20]}`, `m={instr[30],f3}`.
  - f3 001 is legal only with f7=0000000. f3 101 is legal with f7 0000000 or 0100000.
  - Other f3: `b=sext(instr[31:20])`, `m={1'b0,f3}`.
  - `a=rs1`.
- BRANCH (1100011):
  - `m={1'b0,f3}`, `a=rs1`, `b=rs2`, `out_branch=1`, `wb=0`, `rd=0`.
  - f3 010/011 are illegal.
- LUI: `m=0000`, `a=0`, `b={instr[31:12],12'b0}`.
- AUIPC: `m=0000`, `a=pc`, `b={instr[31:12],12'b0}`.
- Write-back: `wb=(rd!=0)` for legal OP/OP-IMM/LUI/AUIPC, else 0. `rd=instr[11:7]` for those ops, else 0.
- Illegal entry: `illegal=1`, `m=0000`, `a=b=0`, `rd=0`, `wb=0`, `branch=0`. It is still issued in order, never dropped.
- Buffer: a main register (drives outputs) plus a skid register.
  - States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
  - EMPTY: transfer in loads main; go to ONE.
  - ONE, transfer in and out together: main reloads; stay in ONE.
  - ONE, transfer in only: write skid; go to FULL.
  - ONE, transfer out only: go to EMPTY.
  - FULL: `in_ready=0`. On transfer out, skid moves to main; go to ONE.
- `in_ready = !skid_valid`, from a register. No combinational path from `out_ready` to `in_ready`.
- Strict FIFO order; no entry lost or duplicated.

## Timing
- Latency: an entry accepted at edge N is on the outputs after edge N, i.e. in cycle N+1 when the buffer was EMPTY or main drains at N.
- Throughput: 1 per cycle while `out_ready=1`.
- Outputs are stable while `out_valid & !out_ready`.
- Reset (asynchronous, including mid-transfer): `out_valid=0`, `in_ready=1`, and all data outputs 0 immediately. Any buffered entries are discarded. Release of `rst_n` is synchronized externally.
- `in_*` inputs are ignored when `in_ready=0`.

## Structure
- Shared package `kiscv_pkg`:
  - Opcode constants: OPC_OP, OPC_OPIMM, OPC_BRANCH, OPC_LUI, OPC_AUIPC.
  - ALU mode constants: ALU_ADD=0000, ALU_SUB=1000, ALU_SLL=0001, ALU_SLT=0010, ALU_SLTU=0011, ALU_XOR=0100, ALU_SRL=0101, ALU_SRA=1101, ALU_OR=0110, ALU_AND=0111.
  - Packed struct `issue_t` {m, a, b, rd, wb, branch, illegal}.
- Sub-module `alu_decode`: purely combinational; maps instr/pc/rs data to `issue_t`.
- Top level holds the buffer registers and the state logic.

## Test plan
- `add x3,x1,x2` (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle `m=0000`, `a=5`, `b=7`, `rd=3`, `wb=1`. Repeat as `sub` (0x402081B3) → `m=1000`.
- `srai x5,x6,3` (0x40335293), rs1=0xF0000000 → `m=1101`, `b=3`, `rd=5`. `addi x1,x0,-1` (0xFFF00093) → `b=0xFFFFFFFF`, `m=0000`.
- `blt x1,x2` (0x0020C063) → `m=0100`, `branch=1`, `wb=0`, `rd=0`. `lui x7,0x12345` (0x123453B7) → `b=0x12345000`, `a=0`. `auipc` with pc=0x100 → `a=0x100`.
- Illegal inputs 0x00000000 and 0x022081B3 (mul) → `illegal=1`, `wb=0`, `a=b=0`, issued in order.
- Backpressure: stream 4 instructions with out_ready low for 3 cycles.
  - `in_ready` falls the cycle after the second accept.
  - Outputs hold steady while stalled.
  - All 4 instructions emerge in order; 1 per cycle after release.
- Assert `rst_n=0` while FULL → `out_valid=0` and `in_ready=1` without waiting for a clock edge. After release, the first new instruction issues with 1-cycle latency.

Source files
------------

// File: rtl/kiscv_pkg.sv
// Shared definitions for the issue stage: RV32I opcodes, ALU modes, issue entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package kiscv_pkg;

  // RV32I major opcodes handled by the issue stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU modes: {funct7[5], funct3} for register ops
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // One decoded entry as it travels to the execute stage
  typedef struct packed {
    logic [3:0]  m;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wb;
    logic        branch;
    logic        illegal;
  } issue_t;

  // Occupancy of the two-entry output buffer
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/alu_issue_if.sv
// Handshake bundle between fetch, the issue stage and the execute stage.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the in_* and out_* sides.
// Modports: slave = issue stage view, master = driver/monitor view.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_m;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        out_wb;
  logic        out_branch;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_m, out_a, out_b, out_rd, out_wb,
           out_branch, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_m, out_a, out_b, out_rd, out_wb,
           out_branch, out_illegal
  );
endinterface

// File: rtl/alu_decode.sv
// Decodes one RV32I instruction into ALU mode, operands and write-back info.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is captured.
// Ports: instr/pc/rs1_data/rs2_data in, iss (issue_t) out.
module alu_decode
  import kiscv_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output issue_t      iss
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd_idx;
  logic       legal;
  logic       is_shift;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign rd_idx   = instr[11:7];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // rs1 index only matters to the register file, which has already been read
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^instr[19:15];

  always_comb begin
    iss   = '0;
    legal = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        legal  = (f7 == 7'b0000000) ||
                 ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        iss.m  = {f7[5], f3};
        iss.a  = rs1_data;
        iss.b  = rs2_data;
        iss.rd = rd_idx;
      end
      OPC_OPIMM: begin
        iss.a  = rs1_data;
        iss.rd = rd_idx;
        if (is_shift) begin
          // only SRAI may carry funct7=0100000
          legal = (f7 == 7'b0000000) ||
                  ((f3 == 3'b101) && (f7 == 7'b0100000));
          iss.m = {instr[30], f3};
          iss.b = {27'b0, instr[24:20]};
        end else begin
          legal = 1'b1;
          iss.m = {1'b0, f3};
          iss.b = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_BRANCH: begin
        legal      = (f3 != 3'b010) && (f3 != 3'b011);
        iss.m      = {1'b0, f3};
        iss.a      = rs1_data;
        iss.b      = rs2_data;
        iss.branch = 1'b1;
      end
      OPC_LUI: begin
        legal  = 1'b1;
        iss.m  = ALU_ADD;
        iss.b  = {instr[31:12], 12'b0};
        iss.rd = rd_idx;
      end
      OPC_AUIPC: begin
        legal  = 1'b1;
        iss.m  = ALU_ADD;
        iss.a  = pc;
        iss.b  = {instr[31:12], 12'b0};
        iss.rd = rd_idx;
      end
      default: legal = 1'b0;
    endcase

    // branches never write back and carry rd=0 already
    iss.wb = legal && !iss.branch && (iss.rd != 5'd0);

    // illegal entries still flow in order, but carry no payload
    if (!legal) begin
      iss         = '0;
      iss.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue stage: decodes one instruction per cycle into a 2-entry skid buffer.
// Latency: entry accepted at edge N is on out_* during cycle N+1 (buffer empty or draining).
// Backpressure: valid/ready both sides; in_ready is registered (=skid empty), full rate under stall.
// Ports: clk, rst_n (async active-low), io (alu_issue_if.slave: in_* from fetch, out_* to execute).
module alu_issue
  import kiscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  alu_issue_if.slave   io
);

  issue_t     dec;
  issue_t     main_q;
  issue_t     skid_q;
  buf_state_t state_q;
  buf_state_t state_d;
  logic       in_ready_q;
  logic       push;
  logic       pop;
  logic       load_main;
  logic       load_skid;
  logic       move_skid;

  alu_decode u_decode (
    .instr    (io.in_instr),
    .pc       (io.in_pc),
    .rs1_data (io.in_rs1_data),
    .rs2_data (io.in_rs2_data),
    .iss      (dec)
  );

  assign push = io.in_valid & in_ready_q;
  assign pop  = (state_q != BUF_EMPTY) & io.out_ready;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    unique case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          load_main = 1'b1;
          state_d   = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          load_main = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          state_d   = BUF_FULL;
        end else if (pop) begin
          state_d   = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        // push cannot happen here: in_ready_q is low whenever FULL
        if (pop) begin
          move_skid = 1'b1;
          state_d   = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // in_ready tracks the next state so it needs no path from out_ready this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != BUF_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= dec;
      end else if (move_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  assign io.in_ready    = in_ready_q;
  assign io.out_valid   = (state_q != BUF_EMPTY);
  assign io.out_m       = main_q.m;
  assign io.out_a       = main_q.a;
  assign io.out_b       = main_q.b;
  assign io.out_rd      = main_q.rd;
  assign io.out_wb      = main_q.wb;
  assign io.out_branch  = main_q.branch;
  assign io.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed cases, backpressure, async reset, random traffic.
// Latency/backpressure checked against an occupancy-queue model of a 2-entry buffer.
// Expected entries come from an instruction-level decode model in this file.
module tb_alu_issue;

  typedef struct packed {
    logic [3:0]  m;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wb;
    logic        branch;
    logic        illegal;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t q[$];

  alu_issue_if io ();

  alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction-level reference: what the execute stage should receive.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
    exp_t       e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         ok;
    e  = '0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ok = 0;
    case (ins[6:0])
      7'h33: begin
        ok   = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.m  = {ins[30], f3};
        e.a  = r1;
        e.b  = r2;
        e.rd = ins[11:7];
      end
      7'h13: begin
        e.a  = r1;
        e.rd = ins[11:7];
        if (f3 == 1 || f3 == 5) begin
          ok  = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
          e.m = {ins[30], f3};
          e.b = 32'(ins[24:20]);
        end else begin
          ok  = 1;
          e.m = {1'b0, f3};
          e.b = 32'($signed(ins[31:20]));
        end
      end
      7'h63: begin
        ok       = (f3 != 2) && (f3 != 3);
        e.m      = {1'b0, f3};
        e.a      = r1;
        e.b      = r2;
        e.branch = 1;
      end
      7'h37: begin
        ok   = 1;
        e.b  = ins & 32'hFFFFF000;
        e.rd = ins[11:7];
      end
      7'h17: begin
        ok   = 1;
        e.a  = pc;
        e.b  = ins & 32'hFFFFF000;
        e.rd = ins[11:7];
      end
      default: ok = 0;
    endcase
    if (ok) begin
      e.wb = (e.rd != 0) && !e.branch;
    end else begin
      e         = '0;
      e.illegal = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h63;
      3: w[6:0] = 7'h37;
      4: w[6:0] = 7'h17;
      5: w[6:0] = 7'h13;
      default: ;
    endcase
    case ($urandom_range(0, 2))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // Called at a falling edge: compare outputs with the model, then drive one cycle.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic ordy, output logic acc);
    chk("in_ready", io.in_ready, q.size() < 2);
    chk("out_valid", io.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_m", io.out_m, q[0].m);
      chk("out_a", io.out_a, q[0].a);
      chk("out_b", io.out_b, q[0].b);
      chk("out_rd", io.out_rd, q[0].rd);
      chk("out_wb", io.out_wb, q[0].wb);
      chk("out_branch", io.out_branch, q[0].branch);
      chk("out_illegal", io.out_illegal, q[0].illegal);
    end
    io.in_valid    = v;
    io.in_instr    = ins;
    io.in_pc       = pc;
    io.in_rs1_data = r1;
    io.in_rs2_data = r2;
    io.out_ready   = ordy;
    acc = v && (q.size() < 2);
    if (ordy && q.size() != 0) void'(q.pop_front());
    if (acc) q.push_back(ref_dec(ins, pc, r1, r2));
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] bp_list [4];
  logic [31:0] ri, rp, r1, r2;
  logic        acc;
  logic        have;
  logic        vld;
  int          idx;

  initial begin
    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    io.in_valid    = 1'b0;
    io.in_instr    = '0;
    io.in_pc       = '0;
    io.in_rs1_data = '0;
    io.in_rs2_data = '0;
    io.out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_in_ready", io.in_ready, 1);
    chk("rst_out_a", io.out_a, 0);
    chk("rst_out_m", io.out_m, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // add x3,x1,x2
    step(1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1, acc);
    chk("add_m", io.out_m, 4'b0000);
    chk("add_a", io.out_a, 5);
    chk("add_b", io.out_b, 7);
    chk("add_rd", io.out_rd, 3);
    chk("add_wb", io.out_wb, 1);
    // sub
    step(1, 32'h402081B3, 32'h0, 32'd5, 32'd7, 1, acc);
    chk("sub_m", io.out_m, 4'b1000);
    // srai x5,x6,3
    step(1, 32'h40335293, 32'h0, 32'hF0000000, 32'h0, 1, acc);
    chk("srai_m", io.out_m, 4'b1101);
    chk("srai_b", io.out_b, 3);
    chk("srai_rd", io.out_rd, 5);
    // addi x1,x0,-1
    step(1, 32'hFFF00093, 32'h0, 32'h0, 32'h0, 1, acc);
    chk("addi_b", io.out_b, 32'hFFFFFFFF);
    // blt x1,x2
    step(1, 32'h0020C063, 32'h0, 32'd1, 32'd2, 1, acc);
    chk("blt_m", io.out_m, 4'b0100);
    chk("blt_branch", io.out_branch, 1);
    chk("blt_wb", io.out_wb, 0);
    // lui x7,0x12345
    step(1, 32'h123453B7, 32'h0, 32'h55, 32'h66, 1, acc);
    chk("lui_b", io.out_b, 32'h12345000);
    chk("lui_a", io.out_a, 0);
    // auipc x4,0x1 at pc 0x100
    step(1, 32'h00001217, 32'h100, 32'h0, 32'h0, 1, acc);
    chk("auipc_a", io.out_a, 32'h100);
    chk("auipc_b", io.out_b, 32'h1000);
    // illegal words, then a legal one to confirm ordering
    step(1, 32'h00000000, 32'h0, 32'h11, 32'h22, 1, acc);
    chk("ill0_illegal", io.out_illegal, 1);
    chk("ill0_a", io.out_a, 0);
    step(1, 32'h022081B3, 32'h0, 32'h11, 32'h22, 1, acc);
    chk("mul_illegal", io.out_illegal, 1);
    chk("mul_wb", io.out_wb, 0);
    chk("mul_b", io.out_b, 0);
    step(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, acc);

    // Backpressure: out_ready low for 3 cycles while streaming 4 instructions
    bp_list[0] = 32'h002081B3;
    bp_list[1] = 32'h402081B3;
    bp_list[2] = 32'h40335293;
    bp_list[3] = 32'h123453B7;
    idx = 0;
    for (int n = 0; n < 12; n++) begin
      if (n == 2) chk("bp_in_ready_low", io.in_ready, 0);
      step(idx < 4, (idx < 4) ? bp_list[idx] : 32'h0, 32'h40, 32'h100 + idx, 32'h200 + idx,
           n >= 3, acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 4);
    chk("bp_drained", q.size(), 0);

    // Async reset while FULL
    step(1, 32'h002081B3, 32'h0, 32'd1, 32'd2, 0, acc);
    step(1, 32'h402081B3, 32'h0, 32'd3, 32'd4, 0, acc);
    chk("full_in_ready", io.in_ready, 0);
    io.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", io.out_valid, 0);
    chk("arst_in_ready", io.in_ready, 1);
    chk("arst_out_a", io.out_a, 0);
    chk("arst_out_b", io.out_b, 0);
    chk("arst_out_rd", io.out_rd, 0);
    q.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    step(1, 32'h002081B3, 32'h0, 32'd9, 32'd10, 1, acc);
    chk("post_rst_valid", io.out_valid, 1);
    chk("post_rst_a", io.out_a, 9);

    // Random traffic with random stalls; instruction held until accepted
    have = 0;
    for (int n = 0; n < 400; n++) begin
      if (!have) begin
        ri   = rand_instr();
        rp   = $urandom;
        r1   = $urandom;
        r2   = $urandom;
        have = 1;
      end
      vld = ($urandom_range(0, 9) < 8);
      step(vld, ri, rp, r1, r2, $urandom_range(0, 9) < 7, acc);
      if (acc) have = 0;
    end
    for (int n = 0; n < 4; n++) step(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, acc);
    chk("final_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
